// File: rtl/timer_ctrl_if.sv
// timer_ctrl_if
//  Groups the button, chain-status and control outputs of the countdown
//  timer control stage.
//  master : the environment (buttons and digit chain) that drives the inputs
//  slave  : timer_ctrl itself
//  Signals:
//   i_btn_start  raw start/pause button, active-high, asynchronous
//   i_btn_clear  raw clear button, active-high, asynchronous
//   i_zero       high when every digit of the chain equals 0
//   o_tick       1-cycle count enable to the least-significant digit
//   o_running    high in RUN
//   o_done       high in DONE
//   o_alarm      blink output, meaningful in DONE only
//   o_state      00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
interface timer_ctrl_if;
   logic       i_btn_start;
   logic       i_btn_clear;
   logic       i_zero;
   logic       o_tick;
   logic       o_running;
   logic       o_done;
   logic       o_alarm;
   logic [1:0] o_state;

   modport master (
      output i_btn_start, i_btn_clear, i_zero,
      input  o_tick, o_running, o_done, o_alarm, o_state
   );

   modport slave (
      input  i_btn_start, i_btn_clear, i_zero,
      output o_tick, o_running, o_done, o_alarm, o_state
   );
endinterface

// File: rtl/timer_ctrl.sv
// timer_ctrl
//  Control stage in front of the BCD down-counter digit chain. Synchronises
//  and debounces the start/pause and clear buttons, runs the
//  IDLE/RUN/PAUSE/DONE state machine, divides clk into a one-cycle count
//  enable and raises a blinking alarm once the chain has reached zero.
//  Parameters:
//   DIV        clk cycles per tick (even, >= 4)
//   DB_CYCLES  consecutive stable synced samples to accept a button change
//  Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    timer_ctrl_if.slave (buttons, i_zero, all outputs)
module timer_ctrl #(
   parameter int DIV       = 50_000_000,
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic         clk,
   input  logic         rst_n,
   timer_ctrl_if.slave  bus
);

   localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int DB_W = $clog2(DB_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_PAUSE = 2'b10,
      S_DONE  = 2'b11
   } state_t;

   // Index 0 = start/pause, index 1 = clear.
   logic [1:0] btn_raw;
   logic [1:0] press;

   assign btn_raw = {bus.i_btn_clear, bus.i_btn_start};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_db
         logic            sync1_reg;
         logic            sync2_reg;
         logic            level_reg;
         logic [DB_W-1:0] cnt_reg;
         logic            accept;

         // The counter holds the number of earlier consecutive mismatching
         // samples, so the current mismatch is the DB_CYCLES-th one here.
         assign accept = (sync2_reg != level_reg) &&
                         (cnt_reg == DB_W'(DB_CYCLES - 1));

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sync1_reg <= 1'b0;
               sync2_reg <= 1'b0;
               level_reg <= 1'b0;
               cnt_reg   <= '0;
            end else begin
               sync1_reg <= btn_raw[gi];
               sync2_reg <= sync1_reg;
               if (sync2_reg == level_reg) begin
                  cnt_reg <= '0;
               end else if (accept) begin
                  level_reg <= sync2_reg;
                  cnt_reg   <= '0;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
         end

         // Event fires in the cycle the new level is accepted so the FSM
         // acts on the same edge that updates the debounced level.
         assign press[gi] = accept & sync2_reg;
      end
   endgenerate

   logic start_ev;
   logic clear_ev;

   assign start_ev = press[0];
   assign clear_ev = press[1];

   state_t        state_reg, state_next;
   logic [PW-1:0] presc_reg, presc_next;
   logic          tick_reg,  tick_next;
   logic          alarm_reg, alarm_next;
   logic          term;
   logic          half;

   assign term = (presc_reg == PW'(DIV - 1));
   assign half = (presc_reg == PW'(DIV / 2 - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
         presc_reg <= '0;
         tick_reg  <= 1'b0;
         alarm_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         presc_reg <= presc_next;
         tick_reg  <= tick_next;
         alarm_reg <= alarm_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      presc_next = presc_reg;
      tick_next  = 1'b0;
      alarm_next = alarm_reg;

      // The prescaler runs in RUN and DONE, including on the edge that
      // leaves RUN for PAUSE, so a resumed period keeps that cycle.
      if (state_reg == S_RUN || state_reg == S_DONE) begin
         presc_next = term ? '0 : presc_reg + 1'b1;
      end

      if (clear_ev) begin
         state_next = S_IDLE;
         presc_next = '0;
         alarm_next = 1'b0;
      end else begin
         unique case (state_reg)
            S_IDLE: begin
               if (start_ev) begin
                  presc_next = '0;
                  if (bus.i_zero) begin
                     state_next = S_DONE;
                     alarm_next = 1'b1;
                  end else begin
                     state_next = S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (start_ev) begin
                  state_next = S_PAUSE;
               end else if (term) begin
                  // Chain already at zero: stop instead of wrapping to 9.
                  if (bus.i_zero) begin
                     state_next = S_DONE;
                     alarm_next = 1'b1;
                  end else begin
                     tick_next = 1'b1;
                  end
               end
            end
            S_PAUSE: begin
               if (start_ev) begin
                  state_next = S_RUN;
               end
            end
            S_DONE: begin
               if (term || half) begin
                  alarm_next = ~alarm_reg;
               end
            end
            default: begin
               state_next = S_IDLE;
            end
         endcase
      end
   end

   assign bus.o_tick    = tick_reg;
   assign bus.o_alarm   = alarm_reg;
   assign bus.o_state   = state_reg;
   assign bus.o_running = (state_reg == S_RUN);
   assign bus.o_done    = (state_reg == S_DONE);

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl
//  Directed and randomized checks of timer_ctrl with DIV=4, DB_CYCLES=3,
//  driving a behavioural 2-digit down-counter chain (value held as an
//  integer) and comparing every cycle against a reference model.
module tb_timer_ctrl;
   localparam int DIV = 4;
   localparam int DB  = 3;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   timer_ctrl_if bus();

   timer_ctrl #(.DIV(DIV), .DB_CYCLES(DB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int chain    = 12;
   int tick_cnt = 0;
   int snap     = 0;
   bit last_tick;
   bit found;

   // Reference model: per-button sample delay, mismatch streak and level;
   // state, RUN cycles since leaving IDLE, cycles since entering DONE.
   bit m_d0 [2];
   bit m_d1 [2];
   bit m_lvl [2];
   int m_streak [2];
   int m_state;
   int m_elapsed;
   int m_done_k;
   bit m_tick;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int b = 0; b < 2; b++) begin
         m_d0[b] = 1'b0; m_d1[b] = 1'b0; m_lvl[b] = 1'b0; m_streak[b] = 0;
      end
      m_state = M_IDLE; m_elapsed = 0; m_done_k = 0; m_tick = 1'b0;
   endtask

   task automatic model_step();
      bit raw [2];
      bit ev [2];
      bit s, zero, term;
      raw[0] = bus.i_btn_start;
      raw[1] = bus.i_btn_clear;
      for (int b = 0; b < 2; b++) begin
         ev[b] = 1'b0;
         s = m_d1[b];
         m_d1[b] = m_d0[b];
         m_d0[b] = raw[b];
         if (s != m_lvl[b]) begin
            m_streak[b]++;
            if (m_streak[b] == DB) begin
               m_lvl[b] = s; m_streak[b] = 0; ev[b] = s;
            end
         end else begin
            m_streak[b] = 0;
         end
      end
      zero   = bus.i_zero;
      m_tick = 1'b0;
      if (ev[1]) begin
         m_state = M_IDLE;
      end else begin
         case (m_state)
            M_IDLE: if (ev[0]) begin
               m_elapsed = 0; m_done_k = 0;
               m_state = zero ? M_DONE : M_RUN;
            end
            M_RUN: begin
               term = ((m_elapsed % DIV) == DIV - 1);
               m_elapsed++;
               if (ev[0]) m_state = M_PAUSE;
               else if (term && zero) begin m_state = M_DONE; m_done_k = 0; end
               else if (term) m_tick = 1'b1;
            end
            M_PAUSE: if (ev[0]) m_state = M_RUN;
            default: m_done_k++;
         endcase
      end
   endtask

   task automatic set_chain(input int v);
      chain = v;
      bus.i_zero = (chain == 0);
   endtask

   // One clock: advance the model with pre-edge inputs, clock the chain
   // with the DUT tick, then compare all outputs on the falling edge.
   task automatic cyc();
      bit tick_now;
      bit exp_alarm;
      tick_now = bus.o_tick;
      if (!rst_n) model_reset(); else model_step();
      @(posedge clk);
      #1;
      if (tick_now && chain > 0) chain--;
      bus.i_zero = (chain == 0);
      @(negedge clk);
      exp_alarm = (m_state == M_DONE) && ((m_done_k % DIV) < DIV / 2);
      chk("state",   bus.o_state,   m_state);
      chk("tick",    bus.o_tick,    m_tick);
      chk("alarm",   bus.o_alarm,   exp_alarm);
      chk("running", bus.o_running, m_state == M_RUN);
      chk("done",    bus.o_done,    m_state == M_DONE);
      last_tick = (bus.o_tick === 1'b1);
      if (last_tick) tick_cnt++;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.i_btn_start = 1'b0;
      bus.i_btn_clear = 1'b0;
      set_chain(12);
      model_reset();
      repeat (2) cyc();
      chk("reset_state", bus.o_state, 0);
      chk("reset_tick",  bus.o_tick, 0);
      rst_n = 1'b1;

      // 1. Glitch shorter than the debounce window
      bus.i_btn_start = 1'b1;
      repeat (2) cyc();
      bus.i_btn_start = 1'b0;
      repeat (8) cyc();
      chk("t1_glitch_idle", bus.o_state, 0);
      chk("t1_glitch_ticks", tick_cnt, 0);

      // 2. Start held 10 cycles
      bus.i_btn_start = 1'b1;
      repeat (4) cyc();
      chk("t2_idle_before", bus.o_state, 0);
      cyc();
      chk("t2_run", bus.o_state, 1);
      repeat (3) cyc();
      chk("t2_no_early_tick", tick_cnt, 0);
      cyc();
      chk("t2_first_tick", bus.o_tick, 1);
      cyc();
      bus.i_btn_start = 1'b0;
      repeat (3) cyc();
      chk("t2_period", bus.o_tick, 1);

      // 4. Pause one cycle after a terminal count, then resume
      repeat (6) cyc();
      found = 1'b0;
      for (int k = 0; k < 8 && !found; k++) begin cyc(); found = last_tick; end
      chk("t4_sync_tick", found, 1);
      bus.i_btn_start = 1'b1;
      repeat (5) cyc();
      chk("t4_pause", bus.o_state, 2);
      repeat (6) cyc();
      bus.i_btn_start = 1'b0;
      snap = tick_cnt;
      repeat (12) cyc();
      chk("t4_no_ticks_paused", tick_cnt - snap, 0);
      bus.i_btn_start = 1'b1;
      repeat (5) cyc();
      chk("t4_resume", bus.o_state, 1);
      snap = tick_cnt;
      repeat (2) cyc();
      chk("t4_no_tick_yet", tick_cnt - snap, 0);
      cyc();
      chk("t4_resume_tick", bus.o_tick, 1);
      repeat (3) cyc();
      bus.i_btn_start = 1'b0;
      repeat (6) cyc();

      // 3. Chain at 01: one tick to 00, then DONE with blinking alarm
      found = 1'b0;
      for (int k = 0; k < 8 && !found; k++) begin cyc(); found = last_tick; end
      chk("t3_sync_tick", found, 1);
      set_chain(1);
      found = 1'b0;
      for (int k = 0; k < 12 && !found; k++) begin cyc(); found = (bus.o_state === 2'b11); end
      chk("t3_done_reached", found, 1);
      chk("t3_chain_zero", chain, 0);
      chk("t3_alarm_k0", bus.o_alarm, 1);
      snap = tick_cnt;
      cyc(); chk("t3_alarm_k1", bus.o_alarm, 1);
      cyc(); chk("t3_alarm_k2", bus.o_alarm, 0);
      cyc(); chk("t3_alarm_k3", bus.o_alarm, 0);
      cyc(); chk("t3_alarm_k4", bus.o_alarm, 1);
      repeat (4) cyc();
      chk("t3_no_tick_done", tick_cnt - snap, 0);
      chk("t3_chain_stays", chain, 0);

      // 5. Clear from DONE, then start+clear together from RUN
      bus.i_btn_clear = 1'b1;
      repeat (6) cyc();
      chk("t5_clear_done", bus.o_state, 0);
      chk("t5_clear_alarm", bus.o_alarm, 0);
      bus.i_btn_clear = 1'b0;
      repeat (6) cyc();
      set_chain(12);
      bus.i_btn_start = 1'b1;
      repeat (6) cyc();
      chk("t5_run", bus.o_state, 1);
      bus.i_btn_start = 1'b0;
      repeat (6) cyc();
      bus.i_btn_start = 1'b1;
      bus.i_btn_clear = 1'b1;
      repeat (5) cyc();
      chk("t5_both_idle", bus.o_state, 0);
      snap = tick_cnt;
      repeat (8) cyc();
      chk("t5_no_ticks", tick_cnt - snap, 0);
      chk("t5_alarm_low", bus.o_alarm, 0);
      bus.i_btn_start = 1'b0;
      bus.i_btn_clear = 1'b0;
      repeat (6) cyc();

      // 6. Reset mid-RUN and mid-debounce
      bus.i_btn_start = 1'b1;
      repeat (6) cyc();
      bus.i_btn_start = 1'b0;
      repeat (7) cyc();
      chk("t6_run", bus.o_state, 1);
      rst_n = 1'b0;
      #1;
      chk("t6_async_state", bus.o_state, 0);
      chk("t6_async_running", bus.o_running, 0);
      cyc();
      rst_n = 1'b1;
      bus.i_btn_start = 1'b1;
      repeat (3) cyc();
      rst_n = 1'b0;
      #1;
      chk("t6_async_idle", bus.o_state, 0);
      cyc();
      rst_n = 1'b1;
      repeat (4) cyc();
      chk("t6_redebounce_wait", bus.o_state, 0);
      cyc();
      chk("t6_redebounce_run", bus.o_state, 1);
      bus.i_btn_start = 1'b0;
      repeat (6) cyc();

      // Randomized buttons, chain reloads and occasional resets
      for (int i = 0; i < 80; i++) begin
         bus.i_btn_start = 1'($urandom_range(0, 1));
         bus.i_btn_clear = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 4) == 0) set_chain(int'($urandom_range(0, 6)));
         rst_n = ($urandom_range(0, 24) != 0);
         repeat ($urandom_range(1, 9)) cyc();
      end
      rst_n = 1'b1;
      repeat (4) cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
